// File: rtl/cpu_pkg.sv
// Shared definitions for the SPI memory controller: command opcodes, access
// size encodings, controller state type and small helper functions.
package cpu_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } spi_state_t;

  // Index of the final bit of a transfer: 32 command/address bits plus the
  // data bytes, counted from zero. Size 3 behaves like a word access.
  function automatic logic [5:0] last_bit_idx(input logic [1:0] size);
    case (size)
      SIZE_BYTE: last_bit_idx = 6'd39;
      SIZE_HALF: last_bit_idx = 6'd47;
      default:   last_bit_idx = 6'd63;
    endcase
  endfunction

  // Bytes arrive in stream order (byte 0 first, each MSB-first), so the
  // receive shifter holds byte 0 in its highest used byte. Reorder into a
  // right-justified little-endian word with unused upper bytes zero.
  function automatic logic [31:0] rx_to_le(input logic [31:0] rx,
                                           input logic [1:0]  size);
    case (size)
      SIZE_BYTE: rx_to_le = {24'h0, rx[7:0]};
      SIZE_HALF: rx_to_le = {16'h0, rx[7:0], rx[15:8]};
      default:   rx_to_le = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
    endcase
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock generator: while enabled, holds sclk low then high for SCLK_HALF
// clk cycles each, and flags the clk edge on which sclk will rise or fall.
// When disabled, sclk returns to its idle-low level.
module spi_clk_gen #(
  parameter int SCLK_HALF = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLK_HALF - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sclk;
  logic             w_phase_end;

  assign w_phase_end = en && (r_cnt == CNT_LAST);
  assign rise        = w_phase_end && !r_sclk;
  assign fall        = w_phase_end && r_sclk;
  assign sclk        = r_sclk;

  // Half-period counter; sclk toggles at the end of each phase.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_phase_end) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 memory controller: one read (0x03) or write (0x02) per request,
// sending command, 24-bit address and 1/2/4 data bytes, with little-endian
// data assembly towards the core.
module spi_mem_ctrl
  import cpu_pkg::*;
#(
  parameter int SCLK_HALF = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        write_en,
  input  logic [1:0]  size,
  input  logic [23:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  input  logic        miso
);

  spi_state_t  r_state, w_next_state;
  logic [63:0] r_shift;
  logic [31:0] r_rx;
  logic [31:0] r_rdata;
  logic [5:0]  r_bit_cnt;
  logic [5:0]  r_last_bit;
  logic        r_we;
  logic [1:0]  r_size;

  logic        w_sclk_en;
  logic        w_rise;
  logic        w_fall;
  logic        w_last;
  logic        w_accept;
  logic [31:0] w_wdata_stream;

  assign w_sclk_en = (r_state == SHIFT);
  assign w_accept  = (r_state == IDLE) && start;
  assign w_last    = w_fall && (r_bit_cnt == r_last_bit);

  // Write bytes go out byte 0 first; read transfers clock out zeros.
  assign w_wdata_stream = write_en ? {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]}
                                   : 32'h0;

  spi_clk_gen #(.SCLK_HALF(SCLK_HALF)) u_clk_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_sclk_en),
    .sclk  (sclk),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic.
  // NOTE: the default assignment first keeps every path driven, so no latch
  // is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start)  w_next_state = SHIFT;
      SHIFT:   if (w_last) w_next_state = FINISH;
      FINISH:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Transaction capture, bit shifting and read-data assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_rx       <= '0;
      r_rdata    <= '0;
      r_bit_cnt  <= '0;
      r_last_bit <= '0;
      r_we       <= 1'b0;
      r_size     <= SIZE_BYTE;
    end else if (w_accept) begin
      r_we       <= write_en;
      r_size     <= size;
      r_last_bit <= last_bit_idx(size);
      r_bit_cnt  <= '0;
      r_shift    <= {(write_en ? SPI_CMD_WRITE : SPI_CMD_READ), address, w_wdata_stream};
    end else if (r_state == SHIFT) begin
      if (w_rise) r_rx <= {r_rx[30:0], miso};
      if (w_fall) begin
        r_shift   <= {r_shift[62:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 6'd1;
      end
      // The final rising edge precedes the final falling edge, so the
      // receive shifter is complete here and rdata is valid alongside done.
      if (w_last && !r_we) r_rdata <= rx_to_le(r_rx, r_size);
    end
  end

  assign mosi  = (r_state == SHIFT) && r_shift[63];
  assign cs_n  = (r_state != SHIFT);
  assign busy  = (r_state == SHIFT);
  assign done  = (r_state == FINISH);
  assign rdata = r_rdata;

endmodule
